// File: rtl/pipe_pkg.sv
// Shared definitions for the core's stage registers: state encoding, payload widths, NOP bubble.
// No logic, so no latency. Occupancy is the numeric value of the state.
// Used by pipe_stage_reg with or without PIPE_STAGE_SKID_EN.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam stage_state_e ST_FULL = ST_ONE;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 72;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc4: 32'd0, instr: NOP_INSTR};

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload register with clear (to CLR_VAL) taking priority over load.
// Latency: one cycle from load to q.
// No handshake of its own; the owning stage decides when to load or clear.
module pipe_skid_entry #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= CLR_VAL;
    else if (clear) q <= CLR_VAL;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with hold and flush; PIPE_STAGE_SKID_EN adds a skid entry.
// Latency: one cycle. Backpressure: base in_ready is combinational from out_ready;
// with the skid entry in_ready depends only on hold and local state.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  stage_state_e      state, state_nxt;
  logic              in_xfer, out_xfer;
  logic              head_load, head_clr;
  logic [DATA_W-1:0] head_d, head_q;
`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load, skid_clr;
  logic [DATA_W-1:0] skid_q;
`endif

  assign out_valid = (state != ST_EMPTY) & ~hold;
`ifdef PIPE_STAGE_SKID_EN
  assign in_ready  = ~rst & ~hold & (state != ST_TWO);
`else
  assign in_ready  = ~rst & ~hold & ((state == ST_EMPTY) | out_ready);
`endif
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  // While held the head stays visible; only an empty stage shows the bubble.
  assign out_data  = (state == ST_EMPTY) ? BUBBLE_VAL : head_q;
  assign occupancy = 2'(state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    head_load = 1'b0;
    head_clr  = 1'b0;
    head_d    = in_data;
`ifdef PIPE_STAGE_SKID_EN
    skid_load = 1'b0;
    skid_clr  = 1'b0;
`endif
    if (flush) begin
      state_nxt = ST_EMPTY;
      head_clr  = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      skid_clr  = 1'b1;
`endif
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_nxt = ST_ONE;
            head_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer & out_xfer) begin
            head_load = 1'b1;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_xfer) begin
            state_nxt = ST_TWO;
            skid_load = 1'b1;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_TWO: begin
          if (out_xfer) begin
            state_nxt = ST_ONE;
            head_load = 1'b1;
            head_d    = skid_q;
            skid_clr  = 1'b1;
          end
        end
`endif
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  pipe_skid_entry #(.DATA_W(DATA_W), .CLR_VAL(BUBBLE_VAL)) u_head (
    .clk   (clk),
    .rst   (rst),
    .load  (head_load),
    .clear (head_clr),
    .d     (head_d),
    .q     (head_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_entry #(.DATA_W(DATA_W), .CLR_VAL(BUBBLE_VAL)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_data),
    .q     (skid_q)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle, plus directed literals.
// Works with PIPE_STAGE_SKID_EN defined or not.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [63:0] BUBBLE = 64'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [1:0]  occupancy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [63:0] mq[$];
  logic [63:0] got[$];
  int          got_cyc[$];
  logic        s_ir, s_ov;
  logic [63:0] s_od;
  logic [1:0]  s_occ;

  pipe_stage_reg #(.DATA_W(64), .BUBBLE_VAL(BUBBLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .hold      (hold),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle, compare DUT against the model, then advance the model at the edge.
  task automatic step(input logic iv, input logic [63:0] d, input logic ordy,
                      input logic h, input logic f);
    logic        e_ir, e_ov, in_x, out_x;
    logic [63:0] e_od;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; hold = h; flush = f;
    #1;
    e_ir = !h && ((mq.size() < CAP) || (CAP == 1 && ordy));
    e_ov = (mq.size() > 0) && !h;
    e_od = (mq.size() > 0) ? mq[0] : BUBBLE;
    chk("in_ready", {63'd0, in_ready}, {63'd0, e_ir});
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_ov});
    chk("out_data", out_data, e_od);
    chk("occupancy", {62'd0, occupancy}, 64'(mq.size()));
    s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_occ = occupancy;
    if (out_valid && ordy) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    in_x  = iv && e_ir;
    out_x = e_ov && ordy;
    @(posedge clk);
    cyc++;
    if (f) mq.delete();
    else begin
      if (out_x) void'(mq.pop_front());
      if (in_x) mq.push_back(d);
    end
  endtask

  initial begin
    int n20, c0;

    // Reset state
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_occ", {62'd0, occupancy}, 64'd0);
    chk("rst_out_data", out_data, BUBBLE);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming 1..4
    got.delete(); got_cyc.delete();
    c0 = cyc;
    for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("stream_cnt", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("stream_d", (i < got.size()) ? got[i] : 64'hx, 64'(i + 1));
      chk("stream_cyc", (i < got_cyc.size()) ? 64'(got_cyc[i]) : 64'hx, 64'(c0 + 1 + i));
    end

`ifndef PIPE_STAGE_SKID_EN
    // Back-pressure on a held 7
    step(1'b1, 64'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 64'd8, 1'b0, 1'b0, 1'b0);
      chk("bp_hold_d", s_od, 64'd7);
      chk("bp_in_ready", {63'd0, s_ir}, 64'd0);
    end
    step(1'b1, 64'd8, 1'b1, 1'b0, 1'b0);
    chk("bp_accept8", {63'd0, s_ir}, 64'd1);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("bp_out8", s_od, 64'd8);
`else
    // Skid absorbs one stalled cycle while streaming 5,6,7
    got.delete(); got_cyc.delete();
    step(1'b1, 64'd5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("skid_occ2", {62'd0, s_occ}, 64'd2);
    chk("skid_in_ready", {63'd0, s_ir}, 64'd0);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("skid_cnt", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("skid_order", (i < got.size()) ? got[i] : 64'hx, 64'(i + 5));
    chk("skid_tput", (got_cyc.size() == 3) ? 64'(got_cyc[2] - got_cyc[1]) : 64'hx, 64'd1);
`endif

    // Flush with a simultaneous input of 0x20
    got.delete();
    step(1'b1, 64'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h20, 1'b1, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("flush_ov", {63'd0, s_ov}, 64'd0);
    chk("flush_od", s_od, BUBBLE);
    chk("flush_occ", {62'd0, s_occ}, 64'd0);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    n20 = 0;
    foreach (got[i]) if (got[i] == 64'h20) n20++;
    chk("flush_no20", 64'(n20), 64'd0);

    // Hold, then flush together with hold
    step(1'b1, 64'h30, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 64'h31, 1'b1, 1'b1, 1'b0);
      chk("hold_ov", {63'd0, s_ov}, 64'd0);
      chk("hold_ir", {63'd0, s_ir}, 64'd0);
      chk("hold_occ", {62'd0, s_occ}, 64'd1);
      chk("hold_od", s_od, 64'h30);
    end
    step(1'b1, 64'h32, 1'b1, 1'b1, 1'b1);
    step(1'b1, 64'h33, 1'b1, 1'b1, 1'b0);
    chk("hf_occ", {62'd0, s_occ}, 64'd0);
    chk("hf_ir", {63'd0, s_ir}, 64'd0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("hf_ir_after", {63'd0, s_ir}, 64'd1);

    // Asynchronous reset while full
    step(1'b1, 64'hDEADBEEF_00000004, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", {63'd0, out_valid}, 64'd0);
    chk("arst_od", out_data, 64'd0);
    chk("arst_occ", {62'd0, occupancy}, 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_ir_after", {63'd0, in_ready}, 64'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 29) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
